mem_block_mover: RTL and testbench

- Block-copy/fill engine sitting directly upstream of the data memory, between the core's load/store path and the memory's address/write/data ports.
- When idle it passes core accesses straight through to memory.
- When started it takes over the memory port and either copies Len bytes from SrcAddr to DstAddr or fills Len bytes at DstAddr with FillVal.
- Gives the core a memcpy/memset primitive without adding instructions to the datapath.

---
 rtl/blkmv_pkg.sv | 15 +
 rtl/mem_block_mover_if.sv | 52 +++++
 rtl/mem_block_mover.sv | 121 ++++++++++++
 tb/tb_mem_block_mover.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blkmv_pkg.sv
// Shared types and constants for the block copy/fill engine.
package blkmv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COPY_RD,
        COPY_WR,
        FILL,
        DONE
    } blkmv_state_t;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

endpackage

// File: rtl/mem_block_mover_if.sv
// Control, core-side and memory-side bundle of mem_block_mover.
// SNACKS_BLKMV_CSUM_EN adds the Csum signal.
interface mem_block_mover_if #(
    parameter int AW = 8
);
    logic          Start;
    logic          Op;
    logic [AW-1:0] SrcAddr;
    logic [AW-1:0] DstAddr;
    logic [AW:0]   Len;
    logic [7:0]    FillVal;
    logic [AW-1:0] CpuAddress;
    logic          CpuWriteMem;
    logic [7:0]    CpuDataIn;
    logic [7:0]    CpuDataOut;
    logic [AW-1:0] MemAddress;
    logic          MemWriteMem;
    logic [7:0]    MemDataIn;
    logic [7:0]    MemDataOut;
    logic          Busy;
    logic          Done;
`ifdef SNACKS_BLKMV_CSUM_EN
    logic [7:0]    Csum;
`endif

    modport slave (
`ifdef SNACKS_BLKMV_CSUM_EN
        output Csum,
`endif
        input  Start, Op, SrcAddr, DstAddr,
        input  Len, FillVal,
        input  CpuAddress, CpuWriteMem, CpuDataIn,
        input  MemDataOut,
        output CpuDataOut, MemAddress,
        output MemWriteMem, MemDataIn,
        output Busy, Done
    );

    modport master (
`ifdef SNACKS_BLKMV_CSUM_EN
        input  Csum,
`endif
        output Start, Op, SrcAddr, DstAddr,
        output Len, FillVal,
        output CpuAddress, CpuWriteMem, CpuDataIn,
        output MemDataOut,
        input  CpuDataOut, MemAddress,
        input  MemWriteMem, MemDataIn,
        input  Busy, Done
    );

endinterface

// File: rtl/mem_block_mover.sv
// memcpy/memset engine in front of the data memory port.
// SNACKS_BLKMV_CSUM_EN adds a running sum of written bytes on Csum.
module mem_block_mover #(
    parameter int AW = 8
) (
    input logic              CLK,
    input logic              ResetN,
    mem_block_mover_if.slave bus
);
    import blkmv_pkg::*;

    localparam logic [AW:0] CntOne = {{AW{1'b0}}, 1'b1};

    blkmv_state_t  state_q;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [AW:0]   cnt_q;
    logic [7:0]    fill_q;
    logic [7:0]    buf_q;
`ifdef SNACKS_BLKMV_CSUM_EN
    logic [7:0]    csum_q;
`endif

    logic [AW-1:0] addr_d;
    logic          we_d;
    logic [7:0]    din_d;

    always_comb begin
        addr_d = bus.CpuAddress;
        we_d   = bus.CpuWriteMem;
        din_d  = bus.CpuDataIn;
        unique case (state_q)
            COPY_RD: begin
                addr_d = src_q;
                we_d   = 1'b0;
                din_d  = buf_q;
            end
            COPY_WR: begin
                addr_d = dst_q;
                we_d   = 1'b1;
                din_d  = buf_q;
            end
            FILL: begin
                addr_d = dst_q;
                we_d   = 1'b1;
                din_d  = fill_q;
            end
            default: ;
        endcase
    end

    assign bus.MemAddress  = addr_d;
    assign bus.MemWriteMem = we_d;
    assign bus.MemDataIn   = din_d;
    assign bus.CpuDataOut  = bus.MemDataOut;
    assign bus.Busy = (state_q == COPY_RD) ||
                      (state_q == COPY_WR) ||
                      (state_q == FILL);
    assign bus.Done = (state_q == DONE);
`ifdef SNACKS_BLKMV_CSUM_EN
    assign bus.Csum = csum_q;
`endif

    always_ff @(posedge CLK) begin
        if (!ResetN) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            buf_q   <= '0;
`ifdef SNACKS_BLKMV_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        src_q  <= bus.SrcAddr;
                        dst_q  <= bus.DstAddr;
                        cnt_q  <= bus.Len;
                        fill_q <= bus.FillVal;
`ifdef SNACKS_BLKMV_CSUM_EN
                        csum_q <= '0;
`endif
                        if (bus.Len == '0)
                            state_q <= DONE;
                        else if (bus.Op == OP_FILL)
                            state_q <= FILL;
                        else
                            state_q <= COPY_RD;
                    end
                end
                COPY_RD: begin
                    buf_q   <= bus.MemDataOut;
                    state_q <= COPY_WR;
                end
                COPY_WR: begin
                    src_q <= src_q + 1'b1;
                    dst_q <= dst_q + 1'b1;
                    cnt_q <= cnt_q - 1'b1;
`ifdef SNACKS_BLKMV_CSUM_EN
                    csum_q <= csum_q + buf_q;
`endif
                    state_q <= (cnt_q == CntOne) ? DONE : COPY_RD;
                end
                FILL: begin
                    dst_q <= dst_q + 1'b1;
                    cnt_q <= cnt_q - 1'b1;
`ifdef SNACKS_BLKMV_CSUM_EN
                    csum_q <= csum_q + fill_q;
`endif
                    state_q <= (cnt_q == CntOne) ? DONE : FILL;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: byte-array memory plus a memcpy/memset model.
module tb_mem_block_mover;

    logic CLK;
    logic ResetN;
    int   checks;
    int   errors;

    logic [7:0] mem [256];
    logic [7:0] mdl [256];

    mem_block_mover_if #(.AW(8)) bus ();

    mem_block_mover #(.AW(8)) dut (
        .CLK    (CLK),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign bus.MemDataOut = mem[bus.MemAddress];

    always @(posedge CLK)
        if (bus.MemWriteMem === 1'b1)
            mem[bus.MemAddress] <= bus.MemDataIn;

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        bus.CpuAddress  = a;
        bus.CpuWriteMem = 1'b1;
        bus.CpuDataIn   = d;
        mdl[a] = d;
    endtask

    task automatic cpu_idle();
        @(negedge CLK);
        bus.CpuWriteMem = 1'b0;
    endtask

    task automatic mem_compare(input string name);
        int bad;
        bad = -1;
        for (int a = 0; a < 256; a++)
            if (mem[a] !== mdl[a] && bad < 0) bad = a;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s mem[%0d] got %h want %h",
                     name, bad, mem[bad], mdl[bad]);
        end
    endtask

    task automatic do_xfer(input logic op, input logic [7:0] src,
                           input logic [7:0] dst, input logic [8:0] len,
                           input logic [7:0] fv, input string name);
        int busy_n, wr_n, cyc, busy_x;
        logic [7:0] v, ck, sa, da;
        ck = 8'h00;
        for (int i = 0; i < int'(len); i++) begin
            sa = src + 8'(i);
            da = dst + 8'(i);
            v = op ? fv : mdl[sa];
            mdl[da] = v;
            ck = ck + v;
        end
        busy_x = op ? int'(len) : 2 * int'(len);
        @(negedge CLK);
        bus.Start   = 1'b1;
        bus.Op      = op;
        bus.SrcAddr = src;
        bus.DstAddr = dst;
        bus.Len     = len;
        bus.FillVal = fv;
        @(negedge CLK);
        bus.Start = 1'b0;
        busy_n = 0;
        wr_n = 0;
        cyc = 0;
        while (bus.Done !== 1'b1 && cyc < 1000) begin
            if (bus.Busy === 1'b1) busy_n++;
            if (bus.MemWriteMem === 1'b1) wr_n++;
            @(negedge CLK);
            cyc++;
        end
        checks++;
        if (cyc >= 1000) begin
            errors++;
            $display("FAIL %s_timeout no Done after %0d cycles", name, cyc);
        end
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done got %b want 0", name, bus.Busy);
        end
        checks++;
        if (busy_n != busy_x) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d want %0d",
                     name, busy_n, busy_x);
        end
        checks++;
        if (wr_n != int'(len)) begin
            errors++;
            $display("FAIL %s_writes got %0d want %0d", name, wr_n, len);
        end
        @(negedge CLK);
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done done %b busy %b want 0 0",
                     name, bus.Done, bus.Busy);
        end
`ifdef SNACKS_BLKMV_CSUM_EN
        checks++;
        if (bus.Csum !== ck) begin
            errors++;
            $display("FAIL %s_csum got %h want %h", name, bus.Csum, ck);
        end
`endif
        mem_compare(name);
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        repeat (2) @(negedge CLK);
        bus.CpuAddress = 8'h3C;
        #1;
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy %b done %b want 0 0",
                     bus.Busy, bus.Done);
        end
        checks++;
        if (bus.MemAddress !== 8'h3C) begin
            errors++;
            $display("FAIL reset_passthru addr %h want 3c", bus.MemAddress);
        end
`ifdef SNACKS_BLKMV_CSUM_EN
        checks++;
        if (bus.Csum !== 8'h00) begin
            errors++;
            $display("FAIL reset_csum got %h want 00", bus.Csum);
        end
`endif
        ResetN = 1'b1;
    endtask

    task automatic init_mem();
        for (int a = 0; a < 256; a++)
            cpu_wr(8'(a), 8'($urandom));
        cpu_idle();
    endtask

    task automatic test_passthrough();
        cpu_wr(8'h10, 8'h5A);
        #1;
        checks++;
        if (bus.MemAddress !== 8'h10 || bus.MemWriteMem !== 1'b1 ||
            bus.MemDataIn !== 8'h5A || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL passthru addr %h we %b din %h busy %b want 10 1 5a 0",
                     bus.MemAddress, bus.MemWriteMem, bus.MemDataIn, bus.Busy);
        end
        cpu_idle();
        checks++;
        if (mem[16] !== 8'h5A || bus.CpuDataOut !== 8'h5A) begin
            errors++;
            $display("FAIL passthru_write mem %h cpu_out %h want 5a 5a",
                     mem[16], bus.CpuDataOut);
        end
    endtask

    task automatic test_copy();
        for (int i = 0; i < 4; i++) cpu_wr(8'(i), 8'(i + 1));
        cpu_idle();
        do_xfer(1'b0, 8'h00, 8'h40, 9'd4, 8'h00, "copy4");
    endtask

    task automatic test_fill_wrap();
        do_xfer(1'b1, 8'h00, 8'hFE, 9'd3, 8'hAA, "fill_wrap");
        do_xfer(1'b1, 8'h00, 8'h90, 9'd3, 8'h90, "fill_csum");
        do_xfer(1'b1, 8'h00, 8'h37, 9'd256, 8'h6B, "fill_all");
        init_mem();
    endtask

    task automatic test_len0_blocked();
        int cyc, busy_n;
        do_xfer(1'b0, 8'h12, 8'h34, 9'd0, 8'h00, "len0");
        for (int i = 0; i < 8; i++) mdl[8'h80 + 8'(i)] = 8'hC3;
        @(negedge CLK);
        bus.Start = 1'b1;
        bus.Op = 1'b1;
        bus.DstAddr = 8'h80;
        bus.Len = 9'd8;
        bus.FillVal = 8'hC3;
        @(negedge CLK);
        bus.Op = 1'b0;
        bus.SrcAddr = 8'h00;
        bus.DstAddr = 8'h20;
        bus.Len = 9'd5;
        bus.CpuAddress = 8'h20;
        bus.CpuDataIn = ~mdl[8'h20];
        bus.CpuWriteMem = 1'b1;
        cyc = 0;
        busy_n = 0;
        while (bus.Busy === 1'b1 && cyc < 100) begin
            busy_n++;
            @(negedge CLK);
            cyc++;
        end
        bus.Start = 1'b0;
        bus.CpuWriteMem = 1'b0;
        checks++;
        if (busy_n != 8 || bus.Done !== 1'b1) begin
            errors++;
            $display("FAIL blocked_fill busy %0d done %b want 8 1",
                     busy_n, bus.Done);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL blocked_start_ignored busy %b want 0", bus.Busy);
        end
        checks++;
        if (mem[32] !== mdl[32]) begin
            errors++;
            $display("FAIL blocked_cpu_write mem %h want %h", mem[32], mdl[32]);
        end
        mem_compare("blocked");
    endtask

    task automatic test_overlap();
        cpu_wr(8'h00, 8'h07);
        cpu_idle();
        do_xfer(1'b0, 8'h00, 8'h01, 9'd3, 8'h00, "overlap");
    endtask

    task automatic test_reset_abort();
        int dn;
        mdl[8'h60] = mdl[8'h50];
        mdl[8'h61] = mdl[8'h51];
        @(negedge CLK);
        bus.CpuAddress = 8'h33;
        bus.Start = 1'b1;
        bus.Op = 1'b0;
        bus.SrcAddr = 8'h50;
        bus.DstAddr = 8'h60;
        bus.Len = 9'd8;
        @(negedge CLK);
        bus.Start = 1'b0;
        repeat (3) @(negedge CLK);
        // Fourth busy cycle writes byte 1; reset lands on its closing edge.
        checks++;
        if (bus.Busy !== 1'b1 || bus.MemWriteMem !== 1'b1 ||
            bus.MemAddress !== 8'h61) begin
            errors++;
            $display("FAIL abort_pre busy %b we %b addr %h want 1 1 61",
                     bus.Busy, bus.MemWriteMem, bus.MemAddress);
        end
        ResetN = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 ||
            bus.MemAddress !== 8'h33) begin
            errors++;
            $display("FAIL abort_post busy %b done %b addr %h want 0 0 33",
                     bus.Busy, bus.Done, bus.MemAddress);
        end
        ResetN = 1'b1;
        dn = 0;
        repeat (20) begin
            @(negedge CLK);
            if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL abort_quiet active cycles %0d want 0", dn);
        end
        mem_compare("abort");
    endtask

    task automatic test_random();
        logic op;
        logic [8:0] len;
        for (int k = 0; k < 8; k++) begin
            op = 1'($urandom_range(0, 1));
            len = 9'($urandom_range(0, 24));
            do_xfer(op, 8'($urandom), 8'($urandom), len,
                    8'($urandom), $sformatf("rand%0d", k));
        end
        do_xfer(1'b0, 8'h10, 8'h90, 9'd256, 8'h00, "copy_all");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ResetN = 1'b0;
        bus.Start = 1'b0;
        bus.Op = 1'b0;
        bus.SrcAddr = '0;
        bus.DstAddr = '0;
        bus.Len = '0;
        bus.FillVal = '0;
        bus.CpuAddress = '0;
        bus.CpuWriteMem = 1'b0;
        bus.CpuDataIn = '0;
        test_reset();
        init_mem();
        test_passthrough();
        test_copy();
        test_fill_wrap();
        test_len0_blocked();
        test_overlap();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
